sensor_i2c_bus_arbiter: RTL and testbench

Shares one sensor I2C pad pair (SCL/SDA) between the hardware I2C sequencer and the software bit-bang register path. Grants ownership by request/grant handshake, switches owners only when the bus is observed idle (no open START, both lines high for a guard period), and flags owners that release without issuing STOP. Sits between both I2C masters and the pad `iobuf` pair, ahead of the pull-ups.

---
 rtl/sensor_i2c_arb_pkg.sv | 25 ++
 rtl/i2c_cond_detect.sv | 80 ++++++++
 rtl/sensor_i2c_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sensor_i2c_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_i2c_arb_pkg
// Description : Shared state and owner encodings for the sensor I2C arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_i2c_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_HW = 2'd1,
    ST_OWN_SW = 2'd2,
    ST_DRAIN  = 2'd3
  } arb_state_e;

  // Codes reported on the owner port
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_HW   = 2'd1,
    OWNER_SW   = 2'd2
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/i2c_cond_detect.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cond_detect
// Description : Pad synchronizer, START/STOP detection, bus_busy tracking and
//               saturating idle-high counter for the shared sensor I2C bus.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_cond_detect #(
  parameter int GUARD_CYCLES = 16,
  parameter int GUARD_BITS   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  input  logic busy_clr,      // force bus_busy low (owner left without STOP)
  input  logic cnt_restart,   // restart the guard count as an owner hands back
  output logic scl_s,
  output logic sda_s,
  output logic bus_busy,
  output logic cnt_at_guard,
  output logic bus_free
);

  localparam logic [GUARD_BITS-1:0] C_GUARD = GUARD_BITS'(GUARD_CYCLES);

  logic                  scl_meta_q, sda_meta_q;
  logic                  scl_sync_q, sda_sync_q;
  logic                  scl_prev_q, sda_prev_q;
  logic                  busy_q, busy_d;
  logic [GUARD_BITS-1:0] cnt_q, cnt_d;
  logic                  start_w, stop_w;

  // Synchronizer, previous-sample history, busy flag and idle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      sda_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      sda_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      scl_meta_q <= scl_in;
      sda_meta_q <= sda_in;
      scl_sync_q <= scl_meta_q;
      sda_sync_q <= sda_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_prev_q <= sda_sync_q;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  // SDA edges only count as conditions when SCL was high on both samples
  always_comb begin
    start_w = scl_prev_q & scl_sync_q & sda_prev_q & ~sda_sync_q;
    stop_w  = scl_prev_q & scl_sync_q & ~sda_prev_q & sda_sync_q;
    busy_d  = busy_q;
    if (start_w)  busy_d = 1'b1;
    if (stop_w)   busy_d = 1'b0;
    if (busy_clr) busy_d = 1'b0;
    cnt_d = cnt_q;
    if (!(scl_sync_q && sda_sync_q) || cnt_restart) begin
      cnt_d = '0;
    end else if (cnt_q != C_GUARD) begin
      cnt_d = cnt_q + GUARD_BITS'(1);
    end
  end

  assign scl_s        = scl_sync_q;
  assign sda_s        = sda_sync_q;
  assign bus_busy     = busy_q;
  assign cnt_at_guard = (cnt_q == C_GUARD);
  assign bus_free     = !busy_q && (cnt_q == C_GUARD);

endmodule
`default_nettype wire

// File: rtl/sensor_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sensor_i2c_bus_arbiter
// Description : Shares one sensor I2C pad pair between the hardware sequencer
//               and the software bit-bang path with round-robin arbitration,
//               idle-guarded handover and missing-STOP detection.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_i2c_bus_arbiter
  import sensor_i2c_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 16,
  parameter int GUARD_BITS   = 5
) (
  input  logic       mclk,
  input  logic       mrst,
  input  logic       hw_req,
  input  logic       sw_req,
  output logic       hw_gnt,
  output logic       sw_gnt,
  input  logic       hw_scl_out,
  input  logic       hw_sda_out,
  input  logic       hw_scl_en,
  input  logic       hw_sda_en,
  input  logic       sw_scl_out,
  input  logic       sw_sda_out,
  input  logic       sw_scl_en,
  input  logic       sw_sda_en,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_s,
  output logic       sda_s,
  output logic       scl_out,
  output logic       sda_out,
  output logic       scl_en,
  output logic       sda_en,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       err_nostop,
  input  logic       err_clr
);

  arb_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic       err_q, err_d;
  logic       scl_out_q, scl_out_d, sda_out_q, sda_out_d;
  logic       scl_en_q, scl_en_d, sda_en_q, sda_en_d;
  logic       busy_clr_w, cnt_restart_w, err_set_w;
  logic       cnt_at_guard_w, bus_free_w;

  i2c_cond_detect #(
    .GUARD_CYCLES (GUARD_CYCLES),
    .GUARD_BITS   (GUARD_BITS)
  ) u_cond (
    .clk          (mclk),
    .rst          (mrst),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .busy_clr     (busy_clr_w),
    .cnt_restart  (cnt_restart_w),
    .scl_s        (scl_s),
    .sda_s        (sda_s),
    .bus_busy     (bus_busy),
    .cnt_at_guard (cnt_at_guard_w),
    .bus_free     (bus_free_w)
  );

  // State, round-robin history, error flag and registered pad drive
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_SW;
      err_q        <= 1'b0;
      scl_out_q    <= 1'b1;
      sda_out_q    <= 1'b1;
      scl_en_q     <= 1'b0;
      sda_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      err_q        <= err_d;
      scl_out_q    <= scl_out_d;
      sda_out_q    <= sda_out_d;
      scl_en_q     <= scl_en_d;
      sda_en_q     <= sda_en_d;
    end
  end

  // Next-state, handover control and pad mux; pads released unless owned
  always_comb begin
    state_d       = state_q;
    last_owner_d  = last_owner_q;
    busy_clr_w    = 1'b0;
    cnt_restart_w = 1'b0;
    err_set_w     = 1'b0;
    scl_out_d     = 1'b1;
    sda_out_d     = 1'b1;
    scl_en_d      = 1'b0;
    sda_en_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_free_w) begin
          if (hw_req && sw_req) begin
            state_d = (last_owner_q == OWNER_HW) ? ST_OWN_SW : ST_OWN_HW;
          end else if (hw_req) begin
            state_d = ST_OWN_HW;
          end else if (sw_req) begin
            state_d = ST_OWN_SW;
          end
        end
      end
      ST_OWN_HW: begin
        if (!hw_req) begin
          state_d       = ST_DRAIN;
          last_owner_d  = OWNER_HW;
          cnt_restart_w = 1'b1;
        end else begin
          scl_out_d = hw_scl_out;
          sda_out_d = hw_sda_out;
          scl_en_d  = hw_scl_en;
          sda_en_d  = hw_sda_en;
        end
      end
      ST_OWN_SW: begin
        if (!sw_req) begin
          state_d       = ST_DRAIN;
          last_owner_d  = OWNER_SW;
          cnt_restart_w = 1'b1;
        end else begin
          scl_out_d = sw_scl_out;
          sda_out_d = sw_sda_out;
          scl_en_d  = sw_scl_en;
          sda_en_d  = sw_sda_en;
        end
      end
      default: begin
        // DRAIN: a transaction still open after the guard period lacked a STOP
        if (cnt_at_guard_w) begin
          if (bus_busy) begin
            err_set_w  = 1'b1;
            busy_clr_w = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
    endcase
    err_d = err_q;
    if (err_clr)   err_d = 1'b0;
    if (err_set_w) err_d = 1'b1;
  end

  assign hw_gnt     = (state_q == ST_OWN_HW);
  assign sw_gnt     = (state_q == ST_OWN_SW);
  assign owner      = (state_q == ST_OWN_HW) ? OWNER_HW :
                      (state_q == ST_OWN_SW) ? OWNER_SW : OWNER_NONE;
  assign scl_out    = scl_out_q;
  assign sda_out    = sda_out_q;
  assign scl_en     = scl_en_q;
  assign sda_en     = sda_en_q;
  assign err_nostop = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_i2c_bus_arbiter
// Description : Directed self-checking bench for sensor_i2c_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_i2c_bus_arbiter;

  localparam int GUARD = 16;

  logic mclk, mrst, hw_req, sw_req, hw_gnt, sw_gnt;
  logic hw_scl_out, hw_sda_out, hw_scl_en, hw_sda_en;
  logic sw_scl_out, sw_sda_out, sw_scl_en, sw_sda_en;
  logic scl_in, sda_in, scl_s, sda_s, scl_out, sda_out, scl_en, sda_en;
  logic [1:0] owner;
  logic bus_busy, err_nostop, err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  sensor_i2c_bus_arbiter #(.GUARD_CYCLES(GUARD), .GUARD_BITS(5)) dut (
    .mclk(mclk), .mrst(mrst), .hw_req(hw_req), .sw_req(sw_req),
    .hw_gnt(hw_gnt), .sw_gnt(sw_gnt),
    .hw_scl_out(hw_scl_out), .hw_sda_out(hw_sda_out),
    .hw_scl_en(hw_scl_en), .hw_sda_en(hw_sda_en),
    .sw_scl_out(sw_scl_out), .sw_sda_out(sw_sda_out),
    .sw_scl_en(sw_scl_en), .sw_sda_en(sw_sda_en),
    .scl_in(scl_in), .sda_in(sda_in), .scl_s(scl_s), .sda_s(sda_s),
    .scl_out(scl_out), .sda_out(sda_out), .scl_en(scl_en), .sda_en(sda_en),
    .owner(owner), .bus_busy(bus_busy), .err_nostop(err_nostop),
    .err_clr(err_clr)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Reset-state snapshot: gnts, owner, en, out, synced, busy, err
  wire [12:0] out_vec = {hw_gnt, sw_gnt, owner, scl_en, sda_en, scl_out,
                         sda_out, scl_s, sda_s, bus_busy, err_nostop};
  localparam logic [12:0] RESET_VEC = 13'b0_0_00_0_0_1_1_1_1_0_0;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    mrst = 1'b1;
    hw_req = 0; sw_req = 0; err_clr = 0;
    hw_scl_out = 1; hw_sda_out = 1; hw_scl_en = 0; hw_sda_en = 0;
    sw_scl_out = 1; sw_sda_out = 1; sw_scl_en = 0; sw_sda_en = 0;
    scl_in = 1; sda_in = 1;
    repeat (2) tick();
    mrst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (out_vec !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", out_vec, RESET_VEC);
    end
  endtask

  task automatic test_hw_grant();
    int k;
    do_reset();
    hw_req = 1;
    k = 0;
    do begin tick(); k++; end while (!hw_gnt && k < 60);
    n_tests++;
    if (k !== 17 || owner !== 2'd1) begin
      n_fail++;
      $display("FAIL hw_grant_latency: got cycles=%0d owner=%0d want 17/1", k, owner);
    end
    hw_scl_en = 1; hw_scl_out = 0;
    n_tests++;
    if (scl_en !== 1'b0) begin
      n_fail++;
      $display("FAIL hw_drive_early: got scl_en=%b want 0", scl_en);
    end
    tick();
    n_tests++;
    if (scl_en !== 1'b1 || scl_out !== 1'b0) begin
      n_fail++;
      $display("FAIL hw_drive: got en=%b out=%b want 1/0", scl_en, scl_out);
    end
    hw_req = 0;
    tick();
    n_tests++;
    if (hw_gnt !== 1'b0 || scl_en !== 1'b0 || scl_out !== 1'b1 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL hw_release: got gnt=%b en=%b out=%b owner=%0d want 0/0/1/0",
               hw_gnt, scl_en, scl_out, owner);
    end
  endtask

  task automatic test_contention();
    int k;
    do_reset();
    hw_req = 1; sw_req = 1;
    k = 0;
    do begin tick(); k++; end while (!hw_gnt && !sw_gnt && k < 60);
    n_tests++;
    if (k !== 17 || hw_gnt !== 1'b1 || sw_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL first_contention: got cycles=%0d hw=%b sw=%b want 17/1/0", k, hw_gnt, sw_gnt);
    end
    sda_in = 0;
    repeat (3) tick();
    n_tests++;
    if (bus_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: got %b want 1", bus_busy);
    end
    sda_in = 1;
    repeat (3) tick();
    n_tests++;
    if (bus_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_busy: got %b want 0", bus_busy);
    end
    hw_req = 0;
    k = 0;
    do begin tick(); k++; end while (!sw_gnt && k < 60);
    n_tests++;
    if (k !== 19 || owner !== 2'd2) begin
      n_fail++;
      $display("FAIL sw_after_hw: got cycles=%0d owner=%0d want 19/2", k, owner);
    end
    // SW hands back and re-requests while HW is pending: HW must win
    hw_req = 1; sw_req = 0;
    tick();
    sw_req = 1;
    k = 1;
    do begin tick(); k++; end while (!hw_gnt && !sw_gnt && k < 60);
    n_tests++;
    if (k !== 19 || hw_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_to_hw: got cycles=%0d hw=%b want 19/1", k, hw_gnt);
    end
    hw_req = 0;
    tick();
    hw_req = 1;
    k = 1;
    do begin tick(); k++; end while (!hw_gnt && !sw_gnt && k < 60);
    n_tests++;
    if (k !== 19 || sw_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_to_sw: got cycles=%0d sw=%b want 19/1", k, sw_gnt);
    end
  endtask

  task automatic test_err_nostop();
    int k;
    int exp_k;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      exp_k = (pass == 0) ? 17 : 1;
      sw_req = 1;
      k = 0;
      do begin tick(); k++; end while (!sw_gnt && k < 60);
      n_tests++;
      if (k !== exp_k) begin
        n_fail++;
        $display("FAIL nostop_grant%0d: got cycles=%0d want %0d", pass, k, exp_k);
      end
      sw_sda_en = 1; sw_sda_out = 0; sda_in = 0;
      tick();
      n_tests++;
      if (sda_en !== 1'b1 || sda_out !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_sda_drive%0d: got en=%b out=%b want 1/0", pass, sda_en, sda_out);
      end
      repeat (2) tick();
      scl_in = 0; sw_scl_en = 1; sw_scl_out = 0;
      repeat (2) tick();
      // Owner walks away mid-transfer; both lines float up together
      sw_req = 0; sw_scl_en = 0; sw_sda_en = 0;
      scl_in = 1; sda_in = 1;
      tick();
      n_tests++;
      if (sw_gnt !== 1'b0 || sda_en !== 1'b0 || scl_en !== 1'b0 || bus_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL nostop_release%0d: got gnt=%b sda_en=%b scl_en=%b busy=%b want 0/0/0/1",
                 pass, sw_gnt, sda_en, scl_en, bus_busy);
      end
      repeat (17) tick();
      n_tests++;
      if (err_nostop !== 1'b0 || bus_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL nostop_early%0d: got err=%b busy=%b want 0/1", pass, err_nostop, bus_busy);
      end
      if (pass == 1) err_clr = 1;
      tick();
      err_clr = 0;
      n_tests++;
      if (err_nostop !== 1'b1 || bus_busy !== 1'b0 || owner !== 2'd0) begin
        n_fail++;
        $display("FAIL nostop_set%0d: got err=%b busy=%b owner=%0d want 1/0/0",
                 pass, err_nostop, bus_busy, owner);
      end
      err_clr = 1;
      tick();
      err_clr = 0;
      n_tests++;
      if (err_nostop !== 1'b0) begin
        n_fail++;
        $display("FAIL err_clr%0d: got %b want 0", pass, err_nostop);
      end
    end
  endtask

  task automatic test_stretch();
    int k;
    int early;
    do_reset();
    hw_req = 1;
    k = 0;
    do begin tick(); k++; end while (!hw_gnt && k < 60);
    sw_req = 1; hw_req = 0; scl_in = 0;
    early = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sw_gnt || hw_gnt) early++;
    end
    n_tests++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL stretch_hold: got %0d granted cycles want 0", early);
    end
    scl_in = 1;
    k = 0;
    do begin tick(); k++; end while (!sw_gnt && k < 60);
    n_tests++;
    if (k !== 20 || err_nostop !== 1'b0) begin
      n_fail++;
      $display("FAIL stretch_grant: got cycles=%0d err=%b want 20/0", k, err_nostop);
    end
  endtask

  task automatic test_glitch_drain();
    int k;
    do_reset();
    hw_req = 1;
    k = 0;
    do begin tick(); k++; end while (!hw_gnt && k < 60);
    hw_req = 0;
    repeat (5) tick();
    sda_in = 0; sw_req = 1;
    tick();
    sda_in = 1;
    tick();
    tick();
    n_tests++;
    if (bus_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start: got busy=%b want 1", bus_busy);
    end
    tick();
    n_tests++;
    if (bus_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_stop: got busy=%b want 0", bus_busy);
    end
    k = 4;
    do begin tick(); k++; end while (!sw_gnt && k < 80);
    n_tests++;
    if (k !== 21 || err_nostop !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_restart: got cycles=%0d err=%b want 21/0", k, err_nostop);
    end
  endtask

  task automatic test_async_reset();
    int k;
    do_reset();
    sw_req = 1;
    k = 0;
    do begin tick(); k++; end while (!sw_gnt && k < 60);
    sw_sda_en = 1; sw_sda_out = 0; sda_in = 0;
    tick();
    n_tests++;
    if (sda_en !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got sda_en=%b want 1", sda_en);
    end
    #2 mrst = 1'b1;
    #1;
    n_tests++;
    if (out_vec !== 13'b0_0_00_0_0_1_1_1_1_0_0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", out_vec, RESET_VEC);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_hw_grant();
    test_contention();
    test_err_nostop();
    test_stretch();
    test_glitch_drain();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
